// File: rtl/cpack_lane_packer.sv
// Packs the enabled 16-bit channel samples of each input beat, in mapper index order,
// densely into 64-bit output words. Up to three leftover lanes are carried between beats.
module cpack_lane_packer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                enable,
    input  logic [1:0]                index_0,
    input  logic [1:0]                index_1,
    input  logic [1:0]                index_2,
    input  logic [1:0]                index_3,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*SAMPLE_WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*SAMPLE_WIDTH-1:0] out_data,
    output logic                      mask_drop
);

    localparam int SW = SAMPLE_WIDTH;

    logic [3*SW-1:0] r_acc;
    logic [2:0]      r_fill;
    logic [3:0]      r_mask_q;
    logic            r_out_valid;
    logic [4*SW-1:0] r_out_data;
    logic            r_mask_drop;

    logic [2:0]      w_n;
    logic [1:0]      w_idx [4];
    logic [4*SW-1:0] w_lanes;
    logic            w_mask_chg;
    logic [2:0]      w_fill_eff;
    logic [2:0]      w_total;
    logic            w_accept;
    logic            w_load;
    logic [3*SW-1:0] w_acc_keep;
    logic [8*SW-1:0] w_cat;

    always_comb begin
        w_n = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            w_n = w_n + {2'b00, enable[c]};
        end
    end

    // Lanes beyond the enabled count are zeroed so no foreign sample can leak into a word.
    always_comb begin
        w_idx[0] = index_0;
        w_idx[1] = index_1;
        w_idx[2] = index_2;
        w_idx[3] = index_3;
        w_lanes  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (3'(k) < w_n) begin
                w_lanes[k*SW +: SW] = in_data[SW*int'(w_idx[k]) +: SW];
            end
        end
    end

    assign w_mask_chg = (enable != r_mask_q);
    assign w_fill_eff = w_mask_chg ? 3'd0 : r_fill;
    assign w_total    = w_fill_eff + w_n;

    assign in_ready = (w_n == 3'd0) || (w_total < 3'd4) || !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && (w_n != 3'd0) && (w_total >= 3'd4);

    // Held lanes stay at the bottom; the new beat's lanes are stacked directly above them.
    always_comb begin
        w_acc_keep = r_acc & ~({(3*SW){1'b1}} << (SW*int'(w_fill_eff)));
        w_cat      = {{(5*SW){1'b0}}, w_acc_keep}
                   | ({{(4*SW){1'b0}}, w_lanes} << (SW*int'(w_fill_eff)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_mask_q    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_mask_drop <= 1'b0;
        end else begin
            r_mask_q    <= enable;
            r_mask_drop <= w_mask_chg && (r_fill != 3'd0);

            if (w_accept && (w_n != 3'd0)) begin
                if (w_total >= 3'd4) begin
                    r_out_data <= w_cat[4*SW-1:0];
                    r_acc      <= w_cat[7*SW-1:4*SW];
                    r_fill     <= w_total - 3'd4;
                end else begin
                    r_acc      <= w_cat[3*SW-1:0];
                    r_fill     <= w_total;
                end
            end else begin
                r_fill <= w_fill_eff;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign mask_drop = r_mask_drop;

endmodule
